// File: rtl/square_complex_arbiter.sv
// square_complex_arbiter
//   Four requesters share one complex-squaring datapath. A round-robin
//   arbiter grants one requester at a time and captures its operand (a + jb).
//   The registered result z^2 = (a^2 - b^2) + j(2ab) is then returned on a
//   valid/ready port, tagged with the requester ID.
// Ports
//   clk, rst_n        clock, async active-low reset
//   req[3:0]          per-requester operand valid
//   reqReal/reqImag   packed signed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt[3:0]          one-hot grant (combinational), operand captured this cycle
//   busy              FSM not in IDLE
//   outValid/outReady result handshake
//   outId/outReal/outImag  result owner and signed 2*WIDTH-bit result
module square_complex_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   reqReal,
  input  logic [4*WIDTH-1:0]   reqImag,
  output logic [3:0]           gnt,
  output logic                 busy,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [1:0]           outId,
  output logic [2*WIDTH-1:0]   outReal,
  output logic [2*WIDTH-1:0]   outImag
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_e;

  state_e                    state_q, state_d;
  logic [1:0]                ptr_q, ptr_d;
  logic [WIDTH-1:0]          a_q, a_d, b_q, b_d;
  logic [1:0]                id_q, id_d;
  logic                      ov_q, ov_d;
  logic [1:0]                oid_q, oid_d;
  logic [2*WIDTH-1:0]        ore_q, ore_d, oim_q, oim_d;

  // Round-robin search starting at the pointer.
  logic                      win_vld;
  logic [1:0]                win_idx, scan_idx;

  always_comb begin
    win_vld  = 1'b0;
    win_idx  = ptr_q;
    scan_idx = ptr_q;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!win_vld && req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  // A grant may only be issued when the capture registers are free: in IDLE,
  // or in HOLD when the current result is leaving this cycle. rst_n gates the
  // grant so nothing is advertised while reset is held.
  logic grant_ok, take;
  assign grant_ok = (state_q == IDLE) || ((state_q == HOLD) && outReady);
  assign take     = rst_n && grant_ok && win_vld;
  assign gnt      = take ? (4'b0001 << win_idx) : 4'b0000;

  // Squaring datapath on sign-extended operands. |a^2 - b^2| <= 2^(2W-2), so
  // the real part always fits; 2ab wraps for a = b = -2^(W-1).
  logic signed [2*WIDTH-1:0] ax, bx, prod_ab, sq_re, sq_im;
  always_comb begin
    ax      = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    bx      = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_ab = ax * bx;
    sq_re   = ax * ax - bx * bx;
    sq_im   = {prod_ab[2*WIDTH-2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    ov_d    = ov_q;
    oid_d   = oid_q;
    ore_d   = ore_q;
    oim_d   = oim_q;
    if (take) begin
      a_d   = reqReal[win_idx*WIDTH +: WIDTH];
      b_d   = reqImag[win_idx*WIDTH +: WIDTH];
      id_d  = win_idx;
      ptr_d = win_idx + 2'd1;
    end
    case (state_q)
      IDLE: if (take) state_d = CALC;
      CALC: begin
        ore_d   = sq_re;
        oim_d   = sq_im;
        oid_d   = id_q;
        ov_d    = 1'b1;
        state_d = HOLD;
      end
      HOLD: if (outReady) begin
        ov_d    = 1'b0;
        state_d = take ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      ov_q    <= 1'b0;
      oid_q   <= '0;
      ore_q   <= '0;
      oim_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      ov_q    <= ov_d;
      oid_q   <= oid_d;
      ore_q   <= ore_d;
      oim_q   <= oim_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign outValid = ov_q;
  assign outId    = oid_q;
  assign outReal  = ore_q;
  assign outImag  = oim_q;

endmodule

// File: tb/tb_square_complex_arbiter.sv
// Bench for square_complex_arbiter: directed operands with hand-computed
// z^2 results. A grant watcher pushes the expected result for the granted
// requester; a monitor pops and compares on each output handshake.
module tb_square_complex_arbiter;
  localparam int W = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req;
  logic [4*W-1:0]  reqReal, reqImag;
  logic [3:0]      gnt;
  logic            busy, outValid, outReady;
  logic [1:0]      outId;
  logic [2*W-1:0]  outReal, outImag;

  square_complex_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .reqReal(reqReal), .reqImag(reqImag),
    .gnt(gnt), .busy(busy), .outValid(outValid), .outReady(outReady),
    .outId(outId), .outReal(outReal), .outImag(outImag)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int cyc = 0;
  logic [33:0] sb[$];
  logic [33:0] mon_e;
  logic [15:0] exp_re[4];
  logic [15:0] exp_im[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Grant watcher: expected result for whoever was granted.
  always @(negedge clk) begin
    if (rst_n && gnt != 4'b0) begin
      chk("gnt onehot", {28'b0, gnt & (gnt - 4'd1)}, 32'd0);
      for (int i = 0; i < 4; i++)
        if (gnt[i]) sb.push_back({2'(i), exp_re[i], exp_im[i]});
    end
  end

  // Reset discards anything in flight.
  always @(negedge rst_n) sb.delete();

  // Result monitor.
  always @(negedge clk) begin
    if (rst_n && outValid && outReady) begin
      if (sb.size() == 0) chk("unexpected result", 32'd1, 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("outId",   {30'b0, outId},   {30'b0, mon_e[33:32]});
        chk("outReal", {16'b0, outReal}, {16'b0, mon_e[31:16]});
        chk("outImag", {16'b0, outImag}, {16'b0, mon_e[15:0]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] er, input logic [15:0] ei);
    reqReal[i*W +: W] = a;
    reqImag[i*W +: W] = b;
    exp_re[i] = er;
    exp_im[i] = ei;
  endtask

  // Returns at the negedge where gnt==m, or after a bounded wait.
  task automatic wait_gnt(input logic [3:0] m, input string nm);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt == m) break;
    end
    chk(nm, {28'b0, gnt}, {28'b0, m});
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!busy && !outValid) break;
    end
    chk("idle", {31'b0, busy | outValid}, 32'd0);
  endtask

  task automatic issue(input int i);
    tick();
    req = 4'(1 << i);
    wait_gnt(4'(1 << i), "issue gnt");
    tick();
    req = 4'b0;
    wait_idle();
  endtask

  int gc[6];

  initial begin
    rst_n = 1'b0; req = 4'b1111; outReady = 1'b1;
    reqReal = '0; reqImag = '0;
    for (int i = 0; i < 4; i++) set_op(i, 8'd0, 8'd0, 16'h0000, 16'h0000);

    // 1: reset state, then first grant goes to requester 0
    repeat (2) @(negedge clk);
    chk("rst gnt", {28'b0, gnt}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst outValid", {31'b0, outValid}, 32'd0);
    chk("rst outReal", {16'b0, outReal}, 32'd0);
    chk("rst outImag", {16'b0, outImag}, 32'd0);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("first gnt", {28'b0, gnt}, 32'h1);
    tick(); req = 4'b0;
    wait_idle();

    // 2: (3,4) -> -7 + j24, latency 2
    set_op(1, 8'd3, 8'd4, 16'hFFF9, 16'h0018);
    tick(); req = 4'b0010;
    wait_gnt(4'b0010, "t2 gnt");
    tick(); req = 4'b0;
    @(negedge clk);
    chk("t2 outValid t+1", {31'b0, outValid}, 32'd0);
    @(negedge clk);
    chk("t2 outValid t+2", {31'b0, outValid}, 32'd1);
    chk("t2 outId", {30'b0, outId}, 32'd1);
    chk("t2 outReal", {16'b0, outReal}, 32'hFFF9);
    wait_idle();

    // 3: round robin with all requesting, fresh pointer
    tick(); rst_n = 1'b0;
    tick(); tick(); rst_n = 1'b1;
    set_op(0, 8'd1, 8'd2, 16'hFFFD, 16'h0004);
    set_op(2, 8'd5, 8'hFF, 16'h0018, 16'hFFF6);
    set_op(3, 8'hFA, 8'd7, 16'hFFF3, 16'hFFAC);
    tick(); req = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      wait_gnt(4'(1 << (g % 4)), "t3 rr order");
      gc[g] = cyc;
      if (g > 0) chk("t3 spacing", 32'(gc[g] - gc[g-1]), 32'd2);
    end
    tick(); req = 4'b0;
    wait_idle();

    // 4: backpressure in HOLD, then grant in the release cycle
    tick(); outReady = 1'b0; req = 4'b0100;
    wait_gnt(4'b0100, "t4 gnt");
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("t4 hold valid", {31'b0, outValid}, 32'd1);
      chk("t4 hold real", {16'b0, outReal}, 32'h0018);
      chk("t4 hold imag", {16'b0, outImag}, 32'hFFF6);
      chk("t4 hold gnt", {28'b0, gnt}, 32'd0);
    end
    tick(); outReady = 1'b1;
    @(negedge clk);
    chk("t4 release gnt", {28'b0, gnt}, 32'h4);
    tick(); req = 4'b0;
    @(negedge clk);
    chk("t4 valid cleared", {31'b0, outValid}, 32'd0);
    wait_idle();

    // 5: extreme operands
    set_op(0, 8'h80, 8'h80, 16'h0000, 16'h8000);
    set_op(3, 8'h80, 8'h00, 16'h4000, 16'h0000);
    issue(0);
    issue(3);

    // 6: reset during CALC
    set_op(1, 8'd3, 8'd4, 16'hFFF9, 16'h0018);
    tick(); req = 4'b0010;
    wait_gnt(4'b0010, "t6 gnt");
    tick(); req = 4'b0; rst_n = 1'b0;
    #1;
    chk("t6 rst busy", {31'b0, busy}, 32'd0);
    chk("t6 rst outValid", {31'b0, outValid}, 32'd0);
    tick(); tick(); rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t6 no stale result", {31'b0, outValid}, 32'd0);
    end
    tick(); req = 4'b1111;
    wait_gnt(4'b0001, "t6 rr after reset");
    tick(); req = 4'b0;
    wait_idle();
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
